// File: rtl/tdp_ram_1clk_be.sv
// Single-clock true dual-port RAM with byte enables, per-port write modes,
// optional output register and deterministic (port A wins) write collisions.
module tdp_ram_1clk_be #(
    parameter int ABITS   = 10,
    parameter int DEPTH   = 1024,
    parameter int DBITS   = 36,
    parameter int BYTE_W  = 9,
    parameter int WMODE_A = 0,
    parameter int WMODE_B = 0,
    parameter int OUT_REG = 0,
    parameter int CNT_W   = 16,
    localparam int NB     = DBITS / BYTE_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_a,
    input  logic             we_a,
    input  logic [NB-1:0]    be_a,
    input  logic [ABITS-1:0] a_a,
    input  logic [DBITS-1:0] wd_a,
    output logic [DBITS-1:0] rd_a,
    input  logic             en_b,
    input  logic             we_b,
    input  logic [NB-1:0]    be_b,
    input  logic [ABITS-1:0] a_b,
    input  logic [DBITS-1:0] wd_b,
    output logic [DBITS-1:0] rd_b,
    output logic             coll,
    output logic [CNT_W-1:0] coll_cnt
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DBITS-1:0] mem_q [DEPTH];

    logic             in_a, in_b;
    logic             wa, wb;
    logic             coll_d;
    logic [DBITS-1:0] old_a, old_b;
    logic [DBITS-1:0] mrg_a, mrg_b;
    logic [DBITS-1:0] rd1_a_d, rd1_b_d;
    logic [DBITS-1:0] rd1_a_q, rd1_b_q;
    logic [DBITS-1:0] rd2_a_q, rd2_b_q;
    logic             en1_a_q, en1_b_q;
    logic             coll_q;
    logic [CNT_W-1:0] cnt_d, cnt_q;

    assign in_a   = 32'(a_a) < DEPTH;
    assign in_b   = 32'(a_b) < DEPTH;
    assign wa     = en_a & we_a & ~rst;
    assign wb     = en_b & we_b & ~rst;
    assign coll_d = wa & wb & (a_a == a_b) & (|(be_a & be_b));

    assign old_a = in_a ? mem_q[a_a[AW-1:0]] : '0;
    assign old_b = in_b ? mem_q[a_b[AW-1:0]] : '0;

    // B is applied first so A overwrites any overlapping lane
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB; i++) begin
            if (wb && in_b && be_b[i])
                mem_q[a_b[AW-1:0]][i*BYTE_W +: BYTE_W] <= wd_b[i*BYTE_W +: BYTE_W];
            if (wa && in_a && be_a[i])
                mem_q[a_a[AW-1:0]][i*BYTE_W +: BYTE_W] <= wd_a[i*BYTE_W +: BYTE_W];
        end
    end

    // On a collision B's write-first view is the final stored word
    always_comb begin
        mrg_a = old_a;
        mrg_b = old_b;
        for (int i = 0; i < NB; i++) begin
            if (be_a[i])
                mrg_a[i*BYTE_W +: BYTE_W] = wd_a[i*BYTE_W +: BYTE_W];
            if (coll_d && be_a[i])
                mrg_b[i*BYTE_W +: BYTE_W] = wd_a[i*BYTE_W +: BYTE_W];
            else if (be_b[i])
                mrg_b[i*BYTE_W +: BYTE_W] = wd_b[i*BYTE_W +: BYTE_W];
        end
    end

    always_comb begin
        rd1_a_d = rd1_a_q;
        if (en_a && !(we_a && WMODE_A == 2)) begin
            if (!in_a)
                rd1_a_d = '0;
            else if (we_a && WMODE_A == 1)
                rd1_a_d = mrg_a;
            else
                rd1_a_d = old_a;
        end
    end

    always_comb begin
        rd1_b_d = rd1_b_q;
        if (en_b && !(we_b && WMODE_B == 2)) begin
            if (!in_b)
                rd1_b_d = '0;
            else if (we_b && WMODE_B == 1)
                rd1_b_d = mrg_b;
            else
                rd1_b_d = old_b;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (coll_d && cnt_q != '1)
            cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd1_a_q <= '0;
            rd1_b_q <= '0;
            rd2_a_q <= '0;
            rd2_b_q <= '0;
            en1_a_q <= 1'b0;
            en1_b_q <= 1'b0;
            coll_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            rd1_a_q <= rd1_a_d;
            rd1_b_q <= rd1_b_d;
            en1_a_q <= en_a;
            en1_b_q <= en_b;
            if (en1_a_q)
                rd2_a_q <= rd1_a_q;
            if (en1_b_q)
                rd2_b_q <= rd1_b_q;
            coll_q  <= coll_d;
            cnt_q   <= cnt_d;
        end
    end

    assign rd_a     = (OUT_REG != 0) ? rd2_a_q : rd1_a_q;
    assign rd_b     = (OUT_REG != 0) ? rd2_b_q : rd1_b_q;
    assign coll     = coll_q;
    assign coll_cnt = cnt_q;

endmodule
